// File: rtl/uart_wb_ctrl_pkg.sv
// Shared encodings for the UART Wishbone sequencer: register map, status bits,
// byte selects, FSM states and the per-state bus request builder.
package uart_wb_ctrl_pkg;

  typedef enum logic [2:0] {
    S_DIV  = 3'd0,
    S_POLL = 3'd1,
    S_DEC  = 3'd2,
    S_RX   = 3'd3,
    S_TX   = 3'd4
  } state_t;

  localparam logic       REG_SD     = 1'b0;
  localparam logic       REG_CD     = 1'b1;
  localparam int         STAT_RXV   = 8;
  localparam int         STAT_TXB   = 9;
  localparam logic [3:0] SEL_STATUS = 4'b0010;
  localparam logic [3:0] SEL_DATA   = 4'b0001;
  localparam logic [3:0] SEL_ALL    = 4'hF;

  typedef struct packed {
    logic        adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Status reads must never set sel[0]: that lane pops the UART receive buffer.
  function automatic wb_req_t build_req(state_t st, logic [31:0] div, logic [7:0] txd);
    wb_req_t req;
    case (st)
      S_DIV:   req = '{adr: REG_CD, we: 1'b1, sel: SEL_ALL,    dat: div};
      S_RX:    req = '{adr: REG_SD, we: 1'b0, sel: SEL_DATA,   dat: 32'd0};
      S_TX:    req = '{adr: REG_SD, we: 1'b1, sel: SEL_DATA,   dat: {24'd0, txd}};
      default: req = '{adr: REG_SD, we: 1'b0, sel: SEL_STATUS, dat: 32'd0};
    endcase
    return req;
  endfunction

endpackage

// File: rtl/uart_wb_ctrl_if.sv
// Private Wishbone link between the sequencer (master) and the UART slave.
interface uart_wb_ctrl_if;
  logic        adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic        we;
  logic [3:0]  sel;
  logic        stb;
  logic        cyc;
  logic        ack;

  modport master (output adr, dat_m2s, we, sel, stb, cyc, input dat_s2m, ack);
  modport slave  (input adr, dat_m2s, we, sel, stb, cyc, output dat_s2m, ack);
endinterface

// File: rtl/uart_wb_ctrl_ack_timer.sv
// Ack watchdog: counts consecutive cycles the strobe waits for ack and flags
// expiry in the cycle the wait reaches ACK_TIMEOUT.
module uart_wb_ctrl_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic i_run,
  output logic o_expire
);
  localparam int            CW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // Any break in the wait restarts the count from zero.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_cnt <= '0;
    end else if (i_run && !o_expire) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_expire = i_run && (r_cnt == LAST);

endmodule

// File: rtl/uart_wb_ctrl.sv
// uart_wb_ctrl: Wishbone master sequencing a simpleuart_wb slave. Programs the
// divider, polls status and arbitrates the UART between a TX and an RX stream.
module uart_wb_ctrl
  import uart_wb_ctrl_pkg::*;
#(
  parameter logic [31:0] DIV_INIT    = 32'd1,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_ni,
  input  logic [31:0]    cfg_div_i,
  input  logic           cfg_div_we_i,
  input  logic [7:0]     tx_data_i,
  input  logic           tx_valid_i,
  output logic           tx_ready_o,
  output logic [7:0]     rx_data_o,
  output logic           rx_valid_o,
  input  logic           rx_ready_i,
  output logic           init_done_o,
  output logic           err_o,
  uart_wb_ctrl_if.master wbm
);

  state_t      r_state, w_state_nxt, w_launch_st;
  logic        r_adr, r_we, r_stb, w_adr_nxt, w_we_nxt, w_stb_nxt;
  logic [3:0]  r_sel, w_sel_nxt;
  logic [31:0] r_dat, w_dat_nxt;
  logic        r_tx_ready, r_rx_valid, r_init_done, r_err;
  logic        w_tx_ready_nxt, w_rx_valid_nxt, w_init_done_nxt, w_err_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_div_pend, w_div_pend_nxt;
  logic [31:0] r_div_val, w_div_val_nxt;
  logic        r_rx_av, r_tx_busy, r_rr_rx, w_rx_av_nxt, w_tx_busy_nxt, w_rr_rx_nxt;
  logic        w_launch, w_rx_elig, w_tx_elig, w_expire, w_run;
  wb_req_t     w_req;

  assign w_run = r_stb && !wbm.ack;

  uart_wb_ctrl_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  // Next-state and next-bus logic; S_DEC launches its chosen transaction directly.
  always_comb begin
    w_state_nxt     = r_state;
    w_adr_nxt       = r_adr;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_dat_nxt       = r_dat;
    w_stb_nxt       = r_stb;
    w_tx_ready_nxt  = 1'b0;
    w_rx_data_nxt   = r_rx_data;
    w_init_done_nxt = r_init_done;
    w_err_nxt       = r_err;
    w_div_pend_nxt  = r_div_pend;
    w_div_val_nxt   = r_div_val;
    w_rx_av_nxt     = r_rx_av;
    w_tx_busy_nxt   = r_tx_busy;
    w_rr_rx_nxt     = r_rr_rx;
    w_launch        = 1'b0;
    w_launch_st     = r_state;
    w_rx_elig       = r_rx_av && !r_rx_valid;
    w_tx_elig       = tx_valid_i && !r_tx_busy;

    if (r_rx_valid && rx_ready_i) begin
      w_rx_valid_nxt = 1'b0;
    end else begin
      w_rx_valid_nxt = r_rx_valid;
    end

    case (r_state)
      S_DEC: begin
        w_launch = 1'b1;
        if (r_div_pend) begin
          w_launch_st = S_DIV;
        end else if (w_rx_elig && w_tx_elig) begin
          w_launch_st = r_rr_rx ? S_RX : S_TX;
          w_rr_rx_nxt = !r_rr_rx;
        end else if (w_rx_elig) begin
          w_launch_st = S_RX;
        end else if (w_tx_elig) begin
          w_launch_st = S_TX;
        end else begin
          w_launch_st = S_POLL;
        end
      end
      S_DIV, S_POLL, S_RX, S_TX: begin
        if (!r_stb) begin
          w_launch = 1'b1;
        end else if (wbm.ack) begin
          w_stb_nxt   = 1'b0;
          w_state_nxt = S_POLL;
          case (r_state)
            S_DIV: begin
              w_init_done_nxt = 1'b1;
              // Only retire the pending request if it is the value just written.
              if (r_div_val == r_dat) begin
                w_div_pend_nxt = 1'b0;
              end else begin
                w_div_pend_nxt = r_div_pend;
              end
            end
            S_POLL: begin
              w_rx_av_nxt   = wbm.dat_s2m[STAT_RXV];
              w_tx_busy_nxt = wbm.dat_s2m[STAT_TXB];
              w_state_nxt   = S_DEC;
            end
            S_RX: begin
              w_rx_data_nxt  = wbm.dat_s2m[7:0];
              w_rx_valid_nxt = 1'b1;
            end
            S_TX:    w_tx_ready_nxt = 1'b1;
            default: w_state_nxt    = S_POLL;
          endcase
        end else if (w_expire) begin
          w_stb_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = (r_state == S_DIV) ? S_DIV : S_POLL;
        end else begin
          w_stb_nxt = r_stb;
        end
      end
      default: begin
        w_state_nxt = S_DIV;
        w_stb_nxt   = 1'b0;
      end
    endcase

    w_req = build_req(w_launch_st, r_div_pend ? r_div_val : DIV_INIT, tx_data_i);
    if (w_launch) begin
      w_state_nxt = w_launch_st;
      w_stb_nxt   = 1'b1;
      w_adr_nxt   = w_req.adr;
      w_we_nxt    = w_req.we;
      w_sel_nxt   = w_req.sel;
      w_dat_nxt   = w_req.dat;
    end else begin
      w_state_nxt = w_state_nxt;
    end

    if (cfg_div_we_i) begin
      w_div_pend_nxt = 1'b1;
      w_div_val_nxt  = cfg_div_i;
    end else begin
      w_div_val_nxt = w_div_val_nxt;
    end
  end

  // State and output registers; reset drops the strobe immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state     <= S_DIV;
      r_adr       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'd0;
      r_dat       <= 32'd0;
      r_stb       <= 1'b0;
      r_tx_ready  <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
      r_div_pend  <= 1'b0;
      r_div_val   <= 32'd0;
      r_rx_av     <= 1'b0;
      r_tx_busy   <= 1'b0;
      r_rr_rx     <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_adr       <= w_adr_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_dat       <= w_dat_nxt;
      r_stb       <= w_stb_nxt;
      r_tx_ready  <= w_tx_ready_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_init_done <= w_init_done_nxt;
      r_err       <= w_err_nxt;
      r_div_pend  <= w_div_pend_nxt;
      r_div_val   <= w_div_val_nxt;
      r_rx_av     <= w_rx_av_nxt;
      r_tx_busy   <= w_tx_busy_nxt;
      r_rr_rx     <= w_rr_rx_nxt;
    end
  end

  assign wbm.adr     = r_adr;
  assign wbm.dat_m2s = r_dat;
  assign wbm.we      = r_we;
  assign wbm.sel     = r_sel;
  assign wbm.stb     = r_stb;
  assign wbm.cyc     = r_stb;
  assign tx_ready_o  = r_tx_ready;
  assign rx_data_o   = r_rx_data;
  assign rx_valid_o  = r_rx_valid;
  assign init_done_o = r_init_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_uart_wb_ctrl.sv
// Directed bench for uart_wb_ctrl against a small behavioural simpleuart_wb slave
// that acks one cycle after stb and logs every completed transaction.
`timescale 1ns/1ps
module tb_uart_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_div = 32'd0;
  logic        cfg_div_we = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        init_done;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  uart_wb_ctrl_if wb ();

  uart_wb_ctrl #(.DIV_INIT(32'd10), .ACK_TIMEOUT(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_ni   (rst_n),
    .cfg_div_i   (cfg_div),
    .cfg_div_we_i(cfg_div_we),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .init_done_o (init_done),
    .err_o       (err),
    .wbm         (wb.master)
  );

  always #5 clk = ~clk;

  // Slave model: bench-owned controls
  logic       sl_mute = 1'b0;
  int         sl_busy_until = 0;
  int         sl_rx_pushed = 0;
  logic [7:0] sl_rx_bytes [0:15];
  // Slave model: slave-owned log
  logic        sl_ack, sl_fresh;
  logic [31:0] sl_dat;
  int          sl_n_polls = 0, sl_n_rx = 0, sl_n_tx = 0, sl_n_cd = 0;
  int          sl_n_badsel = 0, sl_n_tx_nopoll = 0, sl_rx_popped = 0;
  int          sl_polls_at_tx = 0, sl_n_order = 0;
  logic        sl_tx_since_poll = 1'b0;
  logic [31:0] sl_last_cd = 32'd0, sl_first_dat = 32'd0;
  logic [7:0]  sl_last_tx = 8'd0;
  logic [3:0]  sl_last_tx_sel = 4'd0, sl_first_sel = 4'd0;
  logic        sl_first_adr = 1'b0;
  logic [7:0]  sl_order [0:63];

  assign wb.ack     = sl_ack;
  assign wb.dat_s2m = sl_dat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_ack   <= 1'b0;
      sl_dat   <= 32'd0;
      sl_fresh <= 1'b1;
    end else if (sl_ack) begin
      sl_ack <= 1'b0;
      if (wb.stb) begin
        if (sl_fresh) begin
          sl_first_adr <= wb.adr;
          sl_first_dat <= wb.dat_m2s;
          sl_first_sel <= wb.sel;
          sl_fresh     <= 1'b0;
        end
        if (wb.adr) begin
          if (wb.we) begin
            sl_n_cd    <= sl_n_cd + 1;
            sl_last_cd <= wb.dat_m2s;
          end
        end else if (wb.we) begin
          sl_n_tx          <= sl_n_tx + 1;
          sl_last_tx       <= wb.dat_m2s[7:0];
          sl_last_tx_sel   <= wb.sel;
          sl_polls_at_tx   <= sl_n_polls;
          sl_tx_since_poll <= 1'b1;
          if (sl_tx_since_poll) sl_n_tx_nopoll <= sl_n_tx_nopoll + 1;
          if (sl_n_order < 64) sl_order[sl_n_order] <= 8'h54;
          sl_n_order <= sl_n_order + 1;
        end else if (wb.sel == 4'b0001) begin
          sl_n_rx      <= sl_n_rx + 1;
          sl_rx_popped <= sl_rx_popped + 1;
          if (sl_n_order < 64) sl_order[sl_n_order] <= 8'h52;
          sl_n_order <= sl_n_order + 1;
        end else begin
          if (wb.sel != 4'b0010) sl_n_badsel <= sl_n_badsel + 1;
          sl_n_polls       <= sl_n_polls + 1;
          sl_tx_since_poll <= 1'b0;
        end
      end
    end else if (wb.stb && !sl_mute) begin
      sl_ack <= 1'b1;
      sl_dat <= {16'd0, 6'd0, (sl_n_polls < sl_busy_until), (sl_rx_pushed > sl_rx_popped),
                 sl_rx_bytes[sl_rx_popped[3:0]]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int p, tx0, rx0, cd0, ord0, hi;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_stb", {31'd0, wb.stb}, 32'd0);
    chk("rst_cyc", {31'd0, wb.cyc}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_outs", {30'd0, tx_ready, rx_valid}, 32'd0);
    rst_n = 1'b1;

    // Divider programming after reset
    for (int i = 0; i < 20 && sl_n_cd == 0; i++) @(negedge clk);
    chk("init_cd_count", sl_n_cd, 32'd1);
    chk("init_first_adr", {31'd0, sl_first_adr}, 32'd1);
    chk("init_first_dat", sl_first_dat, 32'hA);
    chk("init_first_sel", {28'd0, sl_first_sel}, 32'hF);
    chk("init_done_set", {31'd0, init_done}, 32'd1);

    // TX held off by busy status, then a single write
    tx0 = sl_n_tx;
    p = sl_n_polls;
    sl_busy_until = p + 4;
    for (int i = 0; i < 50 && sl_n_polls < p + 2; i++) @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !tx_ready; i++) @(negedge clk);
    chk("tx_ready_pulse", {31'd0, tx_ready}, 32'd1);
    chk("tx_write_count", sl_n_tx, tx0 + 1);
    chk("tx_write_dat", {24'd0, sl_last_tx}, 32'h55);
    chk("tx_write_sel", {28'd0, sl_last_tx_sel}, 32'h1);
    chk("tx_after_busy_polls", sl_polls_at_tx, p + 5);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_one_cycle", {31'd0, tx_ready}, 32'd0);

    // RX delivery and hold while consumer stalls
    rx0 = sl_n_rx;
    sl_rx_bytes[sl_rx_pushed[3:0]] = 8'hA5;
    sl_rx_pushed++;
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx_valid_set", {31'd0, rx_valid}, 32'd1);
    chk("rx_data_a5", {24'd0, rx_data}, 32'hA5);
    sl_rx_bytes[sl_rx_pushed[3:0]] = 8'h3C;
    sl_rx_pushed++;
    repeat (20) @(negedge clk);
    chk("rx_hold_valid", {31'd0, rx_valid}, 32'd1);
    chk("rx_hold_data", {24'd0, rx_data}, 32'hA5);
    chk("rx_hold_no_read", sl_n_rx, rx0 + 1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("rx_valid_cleared", {31'd0, rx_valid}, 32'd0);
    for (int i = 0; i < 100 && !rx_valid; i++) @(negedge clk);
    chk("rx_data_3c", {24'd0, rx_data}, 32'h3C);
    chk("rx_read_count", sl_n_rx, rx0 + 2);

    // Round-robin between simultaneously eligible RX and TX
    p = sl_n_polls;
    sl_busy_until = p + 100000;
    for (int i = 0; i < 50 && sl_n_polls < p + 2; i++) @(negedge clk);
    tx_data  = 8'h77;
    tx_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sl_rx_bytes[sl_rx_pushed[3:0]] = 8'h10 + 8'(k);
      sl_rx_pushed++;
    end
    p = sl_n_polls;
    for (int i = 0; i < 50 && sl_n_polls == p; i++) @(negedge clk);
    ord0 = sl_n_order;
    sl_busy_until = sl_n_polls;
    rx_ready = 1'b1;
    for (int i = 0; i < 300 && sl_n_order < ord0 + 4; i++) @(negedge clk);
    tx_valid = 1'b0;
    chk("rr_count", sl_n_order, ord0 + 4);
    chk("rr_0_rx", {24'd0, sl_order[ord0]}, 32'h52);
    chk("rr_1_tx", {24'd0, sl_order[ord0 + 1]}, 32'h54);
    chk("rr_2_rx", {24'd0, sl_order[ord0 + 2]}, 32'h52);
    chk("rr_3_tx", {24'd0, sl_order[ord0 + 3]}, 32'h54);
    for (int i = 0; i < 200 && sl_rx_popped != sl_rx_pushed; i++) @(negedge clk);
    chk("rx_drained", sl_rx_popped, sl_rx_pushed);
    chk("status_sel_only_0010", sl_n_badsel, 32'd0);
    chk("tx_always_repolled", sl_n_tx_nopoll, 32'd0);

    // Divider reprogram requested during a TX write; last value wins
    cd0 = sl_n_cd;
    tx0 = sl_n_tx;
    tx_data  = 8'h66;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && !(wb.stb && wb.we && !wb.adr); i++) @(negedge clk);
    chk("cd_tx_in_flight", {31'd0, wb.stb}, 32'd1);
    cfg_div    = 32'h20;
    cfg_div_we = 1'b1;
    @(negedge clk);
    cfg_div = 32'h30;
    @(negedge clk);
    cfg_div_we = 1'b0;
    for (int i = 0; i < 20 && sl_n_tx == tx0; i++) @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 0; i < 100 && sl_n_cd == cd0; i++) @(negedge clk);
    chk("cd_written", sl_n_cd, cd0 + 1);
    chk("cd_value_last", sl_last_cd, 32'h30);
    chk("cd_tx_once", sl_n_tx, tx0 + 1);
    repeat (40) @(negedge clk);
    chk("cd_single_write", sl_n_cd, cd0 + 1);

    // Ack timeout
    chk("err_clear_before", {31'd0, err}, 32'd0);
    for (int i = 0; i < 20 && wb.stb; i++) @(negedge clk);
    sl_mute = 1'b1;
    for (int i = 0; i < 20 && !wb.stb; i++) @(negedge clk);
    hi = 0;
    while (wb.stb && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    chk("timeout_stb_cycles", hi, 32'd16);
    chk("timeout_err_set", {31'd0, err}, 32'd1);
    chk("timeout_no_strobes", {30'd0, tx_ready, rx_valid}, 32'd0);
    sl_mute = 1'b0;
    p = sl_n_polls;
    for (int i = 0; i < 100 && sl_n_polls == p; i++) @(negedge clk);
    chk("timeout_resume_poll", {31'd0, sl_n_polls > p}, 32'd1);
    chk("timeout_err_sticky", {31'd0, err}, 32'd1);

    // Reset in the middle of a transaction, with a divider request pending
    for (int i = 0; i < 20 && !wb.stb; i++) @(negedge clk);
    cfg_div    = 32'h44;
    cfg_div_we = 1'b1;
    @(negedge clk);
    cfg_div_we = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_stb_async", {31'd0, wb.stb}, 32'd0);
    chk("midrst_flags", {30'd0, init_done, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20 && sl_fresh; i++) @(negedge clk);
    chk("midrst_first_adr", {31'd0, sl_first_adr}, 32'd1);
    chk("midrst_first_dat", sl_first_dat, 32'hA);
    chk("midrst_init_done", {31'd0, init_done}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
